// File: rtl/ppl_frame_seq_if.sv
// Pixel-path bundle between the frame sequencer and the scanner, pipeline and
// frame-buffer writer. The sequencer is the slave; the pixel-path side is the master.
interface ppl_frame_seq_if #(
    parameter int ADDR_W = 20,
    parameter int X_W    = 11,
    parameter int Y_W    = 10
);
    logic [ADDR_W-1:0] pixel_addr_out;
    logic              next_en;
    logic              prepare_flag;
    logic              scanner_stop;
    logic [X_W-1:0]    pix_x;
    logic [Y_W-1:0]    pix_y;

    modport master (
        output pixel_addr_out,
        output next_en,
        input  prepare_flag,
        input  scanner_stop,
        input  pix_x,
        input  pix_y
    );

    modport slave (
        input  pixel_addr_out,
        input  next_en,
        output prepare_flag,
        output scanner_stop,
        output pix_x,
        output pix_y
    );
endinterface

// File: rtl/ppl_frame_seq.sv
// Frame sequencer: IDLE -> PREPARE -> RUN -> DRAIN per frame, downstream pixel
// position, frame counter, overrun and delayed vsync. Define PPL_DRAIN_TIMEOUT_EN for the drain watchdog.
module ppl_frame_seq #(
    parameter int H_DISP         = 1280,
    parameter int V_DISP         = 720,
    parameter int ADDR_W         = 20,
    parameter int PREPARE_CYCLES = 5,
    parameter int VS_DELAY       = 2,
    parameter int VS_WIDTH       = 1,
    parameter int FCNT_W         = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              single_shot_i,
    input  logic              start_i,
    ppl_frame_seq_if.slave    bus,
    output logic              busy_o,
    output logic              vs_o,
    output logic [FCNT_W-1:0] frame_cnt_o,
    output logic              overrun_o,
    output logic              timeout_o
);

    localparam int X_W = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam int Y_W = (V_DISP > 1) ? $clog2(V_DISP) : 1;
    localparam logic [ADDR_W-1:0] TOTAL     = ADDR_W'(H_DISP * V_DISP);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(H_DISP - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_DISP - 1);
    localparam logic [3:0]        PREP_LAST = 4'(PREPARE_CYCLES - 1);
    localparam logic [3:0]        VS_HOLD   = 4'(VS_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREPARE,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        prep_cnt_q, prep_cnt_d;
    logic              done_seen_q, done_seen_d;
    logic [X_W-1:0]    pix_x_q, pix_x_d;
    logic [Y_W-1:0]    pix_y_q, pix_y_d;
    logic              scanner_stop_q, scanner_stop_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              overrun_q, overrun_d;
    logic              vs_q, vs_d;
    logic [3:0]        vs_cnt_q, vs_cnt_d;
    logic              counting;
    logic              last_accept;
    logic              frame_done;
    logic              vs_trig;

`ifdef PPL_DRAIN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    assign counting    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign last_accept = bus.next_en && !done_seen_q && (pix_x_q == X_LAST) && (pix_y_q == Y_LAST);
    assign frame_done  = (state_q == S_DRAIN) && (done_seen_q || last_accept);

    always_comb begin
        // NOTE: every _d signal takes its hold value first, so no branch can infer a latch.
        state_d        = state_q;
        prep_cnt_d     = prep_cnt_q;
        done_seen_d    = done_seen_q;
        pix_x_d        = pix_x_q;
        pix_y_d        = pix_y_q;
        scanner_stop_d = scanner_stop_q;
        frame_cnt_d    = frame_cnt_q;
        overrun_d      = 1'b0;
`ifdef PPL_DRAIN_TIMEOUT_EN
        timeout_d      = timeout_q;
        wd_cnt_d       = (state_q == S_DRAIN) ? wd_cnt_q + 1'b1 : '0;
`endif

        // Accepts after the final pixel are flagged, never counted.
        if (counting && bus.next_en) begin
            if (done_seen_q) begin
                overrun_d = 1'b1;
            end else if (pix_x_q == X_LAST) begin
                pix_x_d = '0;
                if (pix_y_q == Y_LAST) begin
                    pix_y_d     = '0;
                    done_seen_d = 1'b1;
                end else begin
                    pix_y_d = pix_y_q + 1'b1;
                end
            end else begin
                pix_x_d = pix_x_q + 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (enable_i && (!single_shot_i || start_i)) begin
                    state_d     = S_PREPARE;
                    prep_cnt_d  = '0;
                    done_seen_d = 1'b0;
                end
            end
            S_PREPARE: begin
                prep_cnt_d = prep_cnt_q + 1'b1;
                if (prep_cnt_q == PREP_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.pixel_addr_out == TOTAL) begin
                    state_d        = S_DRAIN;
                    scanner_stop_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (frame_done) begin
                    state_d        = S_IDLE;
                    scanner_stop_d = 1'b0;
                    frame_cnt_d    = frame_cnt_q + 1'b1;
                end
`ifdef PPL_DRAIN_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    // Abandon the frame: no vsync, no frame count.
                    state_d        = S_IDLE;
                    scanner_stop_d = 1'b0;
                    timeout_d      = 1'b1;
                    pix_x_d        = '0;
                    pix_y_d        = '0;
                    done_seen_d    = 1'b0;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // vs rises VS_DELAY+1 cycles after frame-done; a new trigger reloads the width.
    generate
        if (VS_DELAY == 0) begin : g_vs_nodly
            assign vs_trig = frame_done;
        end else begin : g_vs_dly
            logic [VS_DELAY-1:0] dly_q, dly_d;

            always_comb begin
                dly_d[0] = frame_done;
                for (int i = 1; i < VS_DELAY; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign vs_trig = dly_q[VS_DELAY-1];
        end
    endgenerate

    always_comb begin
        vs_d     = vs_q;
        vs_cnt_d = vs_cnt_q;
        if (vs_trig) begin
            vs_d     = 1'b1;
            vs_cnt_d = VS_HOLD;
        end else if (vs_q) begin
            if (vs_cnt_q == '0) begin
                vs_d = 1'b0;
            end else begin
                vs_cnt_d = vs_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates let every register see the same pre-edge state.
        if (!rst_n) begin
            state_q        <= S_IDLE;
            prep_cnt_q     <= '0;
            done_seen_q    <= 1'b0;
            pix_x_q        <= '0;
            pix_y_q        <= '0;
            scanner_stop_q <= 1'b0;
            frame_cnt_q    <= '0;
            overrun_q      <= 1'b0;
            vs_q           <= 1'b0;
            vs_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            prep_cnt_q     <= prep_cnt_d;
            done_seen_q    <= done_seen_d;
            pix_x_q        <= pix_x_d;
            pix_y_q        <= pix_y_d;
            scanner_stop_q <= scanner_stop_d;
            frame_cnt_q    <= frame_cnt_d;
            overrun_q      <= overrun_d;
            vs_q           <= vs_d;
            vs_cnt_q       <= vs_cnt_d;
        end
    end

`ifdef PPL_DRAIN_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    // The watchdog limit is still a parameter of this build; keep it referenced.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_o          = 1'b0;
`endif

    assign bus.prepare_flag = (state_q == S_IDLE) || (state_q == S_PREPARE);
    assign bus.scanner_stop = scanner_stop_q;
    assign bus.pix_x        = pix_x_q;
    assign bus.pix_y        = pix_y_q;
    assign busy_o           = (state_q != S_IDLE);
    assign vs_o             = vs_q;
    assign frame_cnt_o      = frame_cnt_q;
    assign overrun_o        = overrun_q;

endmodule
